// File: rtl/network_pkg.sv
// Layer-wide sizing helpers shared by the layer sequencer and its neuron cells.
package network_pkg;

  // Potential leak is expressed in 1/256 steps, so the product is shifted by 8.
  localparam int LEAK_SHIFT = 8;

  // Worst-case sum of INPUT_COUNT signed 8-bit weights, plus one guard bit.
  function automatic int acc_width(input int inputs);
    return 8 + $clog2(inputs) + 1;
  endfunction

endpackage

// File: rtl/neuron_pkg.sv
// Neuron data types and the layer sequencer state encoding.
package neuron_pkg;

  typedef logic signed [7:0] weight_t;

  localparam int POT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    UPDATE,
    OUTPUT
  } layer_state_e;

endpackage

// File: rtl/lif_accum_cell.sv
// One leaky integrate-and-fire neuron: synaptic accumulator, membrane
// potential with leak and saturation, threshold compare and refractory hold.
module lif_accum_cell
  import network_pkg::*;
  import neuron_pkg::*;
#(
  parameter int ACC_W          = 12,
  parameter int REFRACT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             add_en,
  input  weight_t          weight,
  input  logic             update_en,
  input  logic [7:0]       leak_factor,
  input  logic [POT_W-1:0] threshold,
  output logic             spike
);

  localparam int REF_W = (REFRACT_CYCLES < 1) ? 1 : $clog2(REFRACT_CYCLES + 1);
  localparam int SUM_W = POT_W + ACC_W + 1;

  logic signed [ACC_W-1:0] acc;
  logic [POT_W-1:0]        potential;
  logic [REF_W-1:0]        refract;
  logic [POT_W-1:0]        leaked;
  logic signed [SUM_W-1:0] sum;
  logic [POT_W-1:0]        next_pot;
  logic                    fire;

  // Synaptic accumulation across the input sweep; cleared when a step starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + {{(ACC_W-8){weight[7]}}, weight};
    end
  end

  // Leak, integrate, saturate to the unsigned potential range, compare.
  always_comb begin
    leaked = potential - POT_W'(({8'd0, potential} * {{POT_W{1'b0}}, leak_factor}) >> LEAK_SHIFT);
    sum    = $signed({{(SUM_W-POT_W){1'b0}}, leaked}) + $signed({{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc});
    if (sum[SUM_W-1]) begin
      next_pot = '0;
    end else if (|sum[SUM_W-2:POT_W]) begin
      next_pot = '1;
    end else begin
      next_pot = sum[POT_W-1:0];
    end
    fire = (next_pot >= threshold);
  end

  // Potential, refractory countdown and the registered spike for this step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      potential <= '0;
      refract   <= '0;
      spike     <= 1'b0;
    end else if (update_en) begin
      if (refract != '0) begin
        potential <= '0;
        spike     <= 1'b0;
        refract   <= refract - REF_W'(1);
      end else if (fire) begin
        potential <= '0;
        spike     <= 1'b1;
        refract   <= REF_W'(REFRACT_CYCLES);
      end else begin
        potential <= next_pot;
        spike     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/neuron_layer_seq.sv
// Spiking neuron layer: sweeps the latched input spike vector one index per
// cycle into NEURON_COUNT cells, updates them, and presents the spike vector.
//
// state  | meaning
// IDLE   | ready for a new time step
// ACCUM  | adding weights of input index idx into every accumulator
// UPDATE | leak/integrate/fire in every cell
// OUTPUT | out_spikes held until the consumer accepts
module neuron_layer_seq
  import network_pkg::*;
  import neuron_pkg::*;
#(
  parameter int INPUT_COUNT    = 16,
  parameter int NEURON_COUNT   = 8,
  parameter int REFRACT_CYCLES = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [INPUT_COUNT-1:0]                 in_spikes,
  input  logic [7:0]                             leak_factor,
  input  weight_t [INPUT_COUNT-1:0][NEURON_COUNT-1:0] weight_reg,
  input  logic [NEURON_COUNT-1:0][POT_W-1:0]     neuron_threshold,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NEURON_COUNT-1:0]                out_spikes
);

  localparam int IDX_W = $clog2(INPUT_COUNT);
  localparam int ACC_W = acc_width(INPUT_COUNT);

  layer_state_e           state;
  layer_state_e           next_state;
  logic [IDX_W-1:0]       idx;
  logic [INPUT_COUNT-1:0] spikes_q;
  logic                   start;
  logic                   last_idx;

  assign start    = in_valid && in_ready;
  assign last_idx = (idx == IDX_W'(INPUT_COUNT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ACCUM;
      end
      ACCUM: begin
        if (last_idx) next_state = UPDATE;
      end
      UPDATE: begin
        next_state = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Input index sweep and the spike vector latched at step start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      spikes_q <= '0;
    end else if (start) begin
      idx      <= '0;
      spikes_q <= in_spikes;
    end else if (state == ACCUM) begin
      idx <= last_idx ? '0 : idx + IDX_W'(1);
    end
  end

  for (genvar i = 0; i < NEURON_COUNT; i++) begin : g_cell
    lif_accum_cell #(
      .ACC_W          (ACC_W),
      .REFRACT_CYCLES (REFRACT_CYCLES)
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (start),
      .add_en      ((state == ACCUM) && spikes_q[idx]),
      .weight      (weight_reg[idx][i]),
      .update_en   (state == UPDATE),
      .leak_factor (leak_factor),
      .threshold   (neuron_threshold[i]),
      .spike       (out_spikes[i])
    );
  end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Bench for neuron_layer_seq: a step-level LIF model predicts every output,
// a negedge process compares each cycle, and literal pins anchor the model.
module tb_neuron_layer_seq;
  import neuron_pkg::*;

  localparam int IC = 4;
  localparam int NC = 2;
  localparam int RC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [IC-1:0] in_spikes = '0;
  logic [7:0] leak_factor = '0;
  weight_t [IC-1:0][NC-1:0] weight_reg;
  logic [NC-1:0][15:0] neuron_threshold;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [NC-1:0] out_spikes;

  int chk_cnt = 0;
  int pass_cnt = 0;

  neuron_layer_seq #(
    .INPUT_COUNT    (IC),
    .NEURON_COUNT   (NC),
    .REFRACT_CYCLES (RC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_spikes        (in_spikes),
    .leak_factor      (leak_factor),
    .weight_reg       (weight_reg),
    .neuron_threshold (neuron_threshold),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_spikes       (out_spikes)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Step-level model state.
  int m_v[NC];
  int m_refr[NC];
  logic [NC-1:0] m_spk;
  bit busy;
  int edges;
  int out_edge;

  function automatic void model_step(input logic [IC-1:0] spk);
    for (int i = 0; i < NC; i++) begin
      int acc = 0;
      int vn;
      for (int j = 0; j < IC; j++) if (spk[j]) acc += int'(weight_reg[j][i]);
      if (m_refr[i] > 0) begin
        m_v[i] = 0;
        m_spk[i] = 1'b0;
        m_refr[i]--;
      end else begin
        vn = m_v[i] - (m_v[i] * int'(leak_factor)) / 256 + acc;
        if (vn < 0) vn = 0;
        if (vn > 65535) vn = 65535;
        if (vn >= int'(neuron_threshold[i])) begin
          m_v[i] = 0;
          m_spk[i] = 1'b1;
          m_refr[i] = RC;
        end else begin
          m_v[i] = vn;
          m_spk[i] = 1'b0;
        end
      end
    end
  endfunction

  // Model sequencing: accepts a step when not busy, retires it on out handshake.
  always @(posedge clk or negedge rst_n) begin
    bit was_busy;
    if (!rst_n) begin
      busy = 1'b0;
      edges = 0;
      out_edge = 0;
      m_spk = '0;
      for (int i = 0; i < NC; i++) begin
        m_v[i] = 0;
        m_refr[i] = 0;
      end
    end else begin
      was_busy = busy;
      if (busy && edges >= out_edge && out_ready) busy = 1'b0;
      edges++;
      if (!was_busy && in_valid) begin
        model_step(in_spikes);
        busy = 1'b1;
        out_edge = edges + IC + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_spikes", out_spikes, 0);
    end else if (busy && edges < out_edge) begin
      check("busy_out_valid", out_valid, 0);
      check("busy_in_ready", in_ready, 0);
    end else if (busy) begin
      check("out_valid", out_valid, 1);
      check("out_spikes", out_spikes, m_spk);
      check("out_in_ready", in_ready, 0);
    end else begin
      check("idle_in_ready", in_ready, 1);
      check("idle_out_valid", out_valid, 0);
    end
  end

  task automatic set_w_all(input int w);
    for (int j = 0; j < IC; j++)
      for (int i = 0; i < NC; i++) weight_reg[j][i] = weight_t'(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_step(input logic [IC-1:0] spk, input int ready_delay, output int lat);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_spikes = spk;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    if (!out_valid) check("timeout_out_valid", 0, 1);
    for (int k = 0; k < ready_delay; k++) begin
      if (k == 1) begin
        in_valid = 1'b1;
        in_spikes = ~spk;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    set_w_all(10);
    neuron_threshold[0] = 16'd30;
    neuron_threshold[1] = 16'd30;
    leak_factor = 8'd0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Three active inputs of +10 reach threshold 30 in one step.
    run_step(4'b0111, 0, lat);
    check("latency", lat, IC + 2);
    check("pin_fire_spk", m_spk, 2'b11);
    check("pin_fire_v", m_v[0], 0);

    // Refractory: two strong steps are silent, the third fires.
    run_step(4'b1111, 0, lat);
    check("pin_refr1", m_spk, 2'b00);
    run_step(4'b1111, 0, lat);
    check("pin_refr2", m_spk, 2'b00);
    run_step(4'b1111, 0, lat);
    check("pin_refr3", m_spk, 2'b11);

    // Integration across two steps.
    do_reset();
    run_step(4'b0011, 0, lat);
    check("pin_int1_spk", m_spk, 2'b00);
    check("pin_int1_v", m_v[1], 20);
    run_step(4'b0011, 0, lat);
    check("pin_int2_spk", m_spk, 2'b11);

    // Clamp at zero and leak behaviour.
    do_reset();
    neuron_threshold[0] = 16'd1000;
    neuron_threshold[1] = 16'd1000;
    run_step(4'b0011, 0, lat);
    set_w_all(-100);
    run_step(4'b0011, 0, lat);
    check("pin_clamp_v", m_v[0], 0);
    check("pin_clamp_spk", m_spk, 2'b00);
    set_w_all(50);
    run_step(4'b0011, 0, lat);
    check("pin_load_v", m_v[0], 100);
    leak_factor = 8'd128;
    run_step(4'b0000, 0, lat);
    check("pin_leak128_v", m_v[0], 50);
    leak_factor = 8'd255;
    run_step(4'b0000, 0, lat);
    check("pin_leak255_v", m_v[1], 1);

    // Threshold 0 fires with no input; distinct per-index weights.
    do_reset();
    leak_factor = 8'd0;
    neuron_threshold[0] = 16'd0;
    neuron_threshold[1] = 16'd1000;
    run_step(4'b0000, 0, lat);
    check("pin_thr0", m_spk, 2'b01);
    neuron_threshold[0] = 16'd25;
    neuron_threshold[1] = 16'd40;
    weight_reg[0][0] = 8'sd5;   weight_reg[0][1] = -8'sd3;
    weight_reg[1][0] = 8'sd20;  weight_reg[1][1] = 8'sd7;
    weight_reg[2][0] = -8'sd8;  weight_reg[2][1] = 8'sd40;
    weight_reg[3][0] = 8'sd1;   weight_reg[3][1] = 8'sd1;
    run_step(4'b1010, 0, lat);
    check("pin_mix1", m_spk, 2'b00);
    run_step(4'b0101, 0, lat);
    check("pin_mix2", m_spk, 2'b10);
    run_step(4'b1111, 0, lat);
    check("pin_mix3_v", m_v[0], 18);
    run_step(4'b1110, 0, lat);
    check("pin_mix4", m_spk, 2'b01);

    // Backpressure with a stray in_valid during OUTPUT.
    do_reset();
    set_w_all(10);
    neuron_threshold[0] = 16'd30;
    neuron_threshold[1] = 16'd30;
    run_step(4'b0111, 5, lat);
    check("pin_bp_spk", m_spk, 2'b11);

    // Reset in the middle of the input sweep discards the step.
    do_reset();
    run_step(4'b0011, 0, lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_spikes = 4'b1111;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    run_step(4'b0011, 0, lat);
    check("pin_after_rst_spk", m_spk, 2'b00);
    check("pin_after_rst_v", m_v[0], 20);
    run_step(4'b0011, 0, lat);
    check("pin_after_rst2", m_spk, 2'b11);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
